// File: rtl/elastic_pipe_stages.sv
// rtl/elastic_pipe_stages.sv - elastic valid/ready stage registers with partial flush and hazard lookup
// Slot 0 is youngest; slot STAGES-1 drives the out_* ports.
module elastic_pipe_stages #(
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 5,
    parameter int STAGES      = 5,
    parameter int FLUSH_DEPTH = 2,
    localparam int OCC_W      = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic [STAGES-1:0] hit_vec,
    output logic [OCC_W-1:0]  occupancy
);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [TAG_W-1:0]  tag_d  [STAGES];
    logic [STAGES-1:0] adv;

    // A slot may advance when the consumer takes the head or any slot at or ahead of it is empty.
    always_comb begin
        logic hole;
        hole = 1'b0;
        adv  = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            hole   = hole | ~valid_q[i];
            adv[i] = out_ready | hole;
        end
    end

    assign in_ready = adv[0] & ~flush;

    always_comb begin
        logic kill_load;
        logic kill_hold;
        valid_d[0] = adv[0] ? (in_valid & in_ready) : (valid_q[0] & ~flush);
        data_d[0]  = adv[0] ? in_data : data_q[0];
        tag_d[0]   = adv[0] ? in_tag  : tag_q[0];
        for (int i = 1; i < STAGES; i++) begin
            // An item leaving the flushed region on the flush edge is killed in flight.
            kill_load  = flush && (i <= FLUSH_DEPTH);
            kill_hold  = flush && (i < FLUSH_DEPTH);
            valid_d[i] = adv[i] ? (valid_q[i-1] & ~kill_load) : (valid_q[i] & ~kill_hold);
            data_d[i]  = adv[i] ? data_q[i-1] : data_q[i];
            tag_d[i]   = adv[i] ? tag_q[i-1]  : tag_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < STAGES; i++) begin
            hit_vec[i] = valid_q[i] && (tag_q[i] == lookup_tag) && (lookup_tag != '0);
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + {{(OCC_W-1){1'b0}}, valid_q[i]};
        end
    end

endmodule

// File: tb/tb_elastic_pipe_stages.sv
// tb/tb_elastic_pipe_stages.sv - vector table, corner sequences and random run against a position-queue model
module tb_elastic_pipe_stages;
    localparam int S  = 5;
    localparam int FD = 2;
    localparam int DW = 32;
    localparam int TW = 5;
    localparam int OW = $clog2(S + 1);

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [TW-1:0] in_tag, out_tag, lookup_tag;
    logic [S-1:0]  hit_vec;
    logic [OW-1:0] occupancy;

    always #5 clk = ~clk;

    elastic_pipe_stages #(.DATA_W(DW), .TAG_W(TW), .STAGES(S), .FLUSH_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .lookup_tag(lookup_tag), .hit_vec(hit_vec), .occupancy(occupancy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: queue of live items, oldest first, each knowing its slot position.
    typedef struct {
        int            pos;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } item_t;
    item_t       mq[$];
    int          np[S];
    bit          m_adv0;
    logic [TW-1:0] got[$];

    logic          o_valid, o_ready;
    logic [TW-1:0] o_tag;
    logic [S-1:0]  o_hit;
    int            o_occ;

    // Each item moves one slot forward unless the item directly ahead stays put.
    task automatic m_eval(input logic ordy);
        int nxt;
        nxt = S;
        for (int k = 0; k < mq.size(); k++) begin
            int p;
            int q;
            p = mq[k].pos;
            if (p == S - 1) q = ordy ? S : S - 1;
            else            q = (p + 1 < nxt - 1) ? p + 1 : nxt - 1;
            np[k] = q;
            nxt   = q;
        end
        m_adv0 = (nxt > 0);
    endtask

    task automatic step(input logic iv, input logic [DW-1:0] d, input logic [TW-1:0] t,
                        input logic fl, input logic ordy, input logic [TW-1:0] lk);
        logic          e_ov;
        logic [S-1:0]  e_hit;
        item_t         nq[$];
        item_t         it;
        @(negedge clk);
        in_valid = iv; in_data = d; in_tag = t; flush = fl; out_ready = ordy; lookup_tag = lk;
        #1;
        m_eval(ordy);
        e_ov  = (mq.size() > 0) && (mq[0].pos == S - 1);
        e_hit = '0;
        foreach (mq[k]) if (lk != 0 && mq[k].tag == lk) e_hit[mq[k].pos] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(m_adv0 & ~fl));
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("hit_vec", 64'(hit_vec), 64'(e_hit));
        if (e_ov) begin
            chk("out_data", 64'(out_data), 64'(mq[0].data));
            chk("out_tag", 64'(out_tag), 64'(mq[0].tag));
        end
        o_valid = out_valid; o_ready = in_ready; o_tag = out_tag; o_hit = hit_vec; o_occ = int'(occupancy);
        if (out_valid && ordy) got.push_back(out_tag);
        for (int k = 0; k < mq.size(); k++) begin
            if (np[k] == S) continue;
            if (fl && mq[k].pos < FD) continue;
            it = mq[k];
            it.pos = np[k];
            nq.push_back(it);
        end
        if (iv && m_adv0 && !fl) begin
            it.pos = 0; it.data = d; it.tag = t;
            nq.push_back(it);
        end
        mq = nq;
    endtask

    task automatic idle(input logic ordy, input logic [TW-1:0] lk);
        step(1'b0, '0, '0, 1'b0, ordy, lk);
    endtask

    task automatic push(input logic [TW-1:0] t, input logic ordy);
        step(1'b1, 32'h100 + 32'(t), t, 1'b0, ordy, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        mq.delete();
        got.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic          iv;
        logic [TW-1:0] tag;
        logic          ordy;
        logic          e_ready;
        logic          e_ov;
        logic [TW-1:0] e_otag;
        int            e_occ;
    } vec_t;
    vec_t tbl[9];

    initial begin
        int first_ov;
        int peak;
        int first_ret;
        int last_ret;
        int nret;

        tbl[0] = '{1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 5'd0, 0};
        tbl[1] = '{1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1};
        tbl[2] = '{1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 2};
        tbl[3] = '{1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 5'd0, 3};
        tbl[4] = '{1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 4};
        tbl[5] = '{1'b1, 5'd6, 1'b0, 1'b0, 1'b1, 5'd1, 5};
        tbl[6] = '{1'b1, 5'd6, 1'b0, 1'b0, 1'b1, 5'd1, 5};
        tbl[7] = '{1'b1, 5'd6, 1'b1, 1'b1, 1'b1, 5'd1, 5};
        tbl[8] = '{1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd2, 5};

        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b0; lookup_tag = '0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_hit_vec", 64'(hit_vec), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Stream fill/drain with no backpressure
        first_ov = -1; peak = 0; first_ret = -1; last_ret = -1;
        for (int k = 0; k < 16; k++) begin
            step(k < 8, 32'h100 + 32'(k + 1), TW'(k + 1), 1'b0, 1'b1, '0);
            if (o_valid && first_ov < 0) first_ov = k;
            if (o_valid) begin
                if (first_ret < 0) first_ret = k;
                last_ret = k;
            end
            if (o_occ > peak) peak = o_occ;
        end
        chk("stream_latency", 64'(first_ov), 64'(S));
        chk("stream_peak_occ", 64'(peak), 64'(S));
        chk("stream_no_gaps", 64'(last_ret - first_ret), 64'd7);
        chk("stream_count", 64'(got.size()), 64'd8);
        nret = got.size();
        for (int k = 0; k < 8 && k < nret; k++) chk("stream_order", 64'(got[k]), 64'(k + 1));
        chk("stream_drained", 64'(occupancy), 64'd0);

        // Full backpressure table
        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].iv, 32'h100 + 32'(tbl[i].tag), tbl[i].tag, 1'b0, tbl[i].ordy, '0);
            chk("tbl_in_ready", 64'(o_ready), 64'(tbl[i].e_ready));
            chk("tbl_out_valid", 64'(o_valid), 64'(tbl[i].e_ov));
            chk("tbl_occupancy", 64'(o_occ), 64'(tbl[i].e_occ));
            if (tbl[i].e_ov) chk("tbl_out_tag", 64'(o_tag), 64'(tbl[i].e_otag));
        end

        // Bubble collapse
        do_reset();
        push(5'd1, 1'b0);
        repeat (3) idle(1'b0, '0);
        push(5'd2, 1'b0);
        repeat (3) idle(1'b0, '0);
        idle(1'b0, 5'd1);
        chk("bubble_slot4", 64'(o_hit), 64'b10000);
        idle(1'b0, 5'd2);
        chk("bubble_slot3", 64'(o_hit), 64'b01000);
        chk("bubble_occ", 64'(o_occ), 64'd2);

        // Flush with output retiring on the same edge
        do_reset();
        for (int t = 1; t <= 5; t++) push(TW'(t), 1'b0);
        step(1'b1, 32'h109, 5'd9, 1'b1, 1'b1, '0);
        chk("flush_in_ready", 64'(o_ready), 64'd0);
        chk("flush_occ0", 64'(o_occ), 64'd5);
        idle(1'b1, '0);
        chk("flush_occ1", 64'(o_occ), 64'd2);
        idle(1'b1, '0);
        chk("flush_occ2", 64'(o_occ), 64'd1);
        idle(1'b1, '0);
        chk("flush_occ3", 64'(o_occ), 64'd0);
        chk("flush_ret_count", 64'(got.size()), 64'd3);
        nret = got.size();
        for (int k = 0; k < 3 && k < nret; k++) chk("flush_ret_tag", 64'(got[k]), 64'(k + 1));

        // Hazard lookup: slots 0..4 hold tags 3,0,7,3,0
        do_reset();
        push(5'd0, 1'b0); push(5'd3, 1'b0); push(5'd7, 1'b0); push(5'd0, 1'b0); push(5'd3, 1'b0);
        idle(1'b0, 5'd3);
        chk("hit_tag3", 64'(o_hit), 64'b01001);
        idle(1'b0, 5'd0);
        chk("hit_tag0", 64'(o_hit), 64'd0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 5'd3);
        idle(1'b0, 5'd3);
        chk("hit_after_flush", 64'(o_hit), 64'b01000);
        chk("hit_after_flush_occ", 64'(o_occ), 64'd3);

        // Asynchronous reset mid-stream
        do_reset();
        push(5'd1, 1'b0); push(5'd2, 1'b0); push(5'd3, 1'b0);
        idle(1'b0, '0); idle(1'b0, '0);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_occ", 64'(occupancy), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        mq.delete();
        got.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (8) idle(1'b1, '0);
        chk("no_stale_items", 64'(got.size()), 64'd0);

        // Random traffic against the model
        do_reset();
        for (int k = 0; k < 800; k++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, TW'($urandom_range(0, 7)),
                 1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 2) != 0),
                 TW'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
